// File: rtl/mem_responder.sv
// mem_responder: single-outstanding-request memory model with fixed latency.
//
// A request is accepted in IDLE and then held for LATENCY cycles. The memory
// access happens on the edge that enters RESP. The response is then held until
// the requester takes it. Out-of-range and misaligned requests complete with
// the same timing, but they report resp_error and never write to the array.
//
// Ports:
//   clk         single clock, all state on rising edge
//   reset       asynchronous active-low reset (memory contents are kept)
//   req_valid   request present                 req_ready  accepting (IDLE only)
//   req_write   1 = store, 0 = load              req_byte   1 = byte, 0 = word
//   req_addr    byte address                     req_wdata  store data (byte: [7:0])
//   resp_valid  response present (RESP only)    resp_ready requester takes response
//   resp_rdata  load data, 0 for stores/errors   resp_error out of range / misaligned
module mem_responder #(
  parameter int unsigned               ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0]   BASE_ADDRESS = 32'h1000,
  parameter logic [ADDRESS_SIZE-1:0]   MEM_SIZE     = 32'h1000,
  parameter int unsigned               LATENCY      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [ADDRESS_SIZE-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ADDRESS_SIZE-1:0] resp_rdata,
  output logic                    resp_error
);

  localparam int unsigned WORDS = int'(MEM_SIZE >> 2);
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  // One extra bit so that address + size cannot wrap past the top of the space.
  localparam logic [ADDRESS_SIZE:0] LIMIT = {1'b0, BASE_ADDRESS} + {1'b0, MEM_SIZE};

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic                    r_write;
  logic                    r_byte;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [ADDRESS_SIZE-1:0] r_wdata;
  logic [ADDRESS_SIZE-1:0] r_rdata;
  logic                    r_error;
  logic [ADDRESS_SIZE-1:0] r_mem [WORDS];

  logic                    w_accept;
  logic                    w_fire;
  logic [ADDRESS_SIZE:0]   w_end;
  logic                    w_err;
  logic [IDX_W-1:0]        w_idx;
  logic [4:0]              w_lane;
  logic [ADDRESS_SIZE-1:0] w_word;
  logic [ADDRESS_SIZE-1:0] w_load;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid)  w_next = BUSY;
      BUSY:    if (r_cnt == '0) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
  end

  assign w_accept = req_valid && req_ready;
  assign w_fire   = (r_state == BUSY) && (r_cnt == '0);

  // Latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= 4'(LATENCY - 1);
    end else if ((r_state == BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture; the request inputs are only looked at in IDLE
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_byte  <= req_byte;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // End address is addr+1 for bytes and addr+4 for words.
  assign w_end  = {1'b0, r_addr} + {{(ADDRESS_SIZE-2){1'b0}}, ~r_byte, 1'b0, r_byte};
  assign w_err  = (r_addr < BASE_ADDRESS) || (w_end > LIMIT) ||
                  (!r_byte && (r_addr[1:0] != 2'b00));
  assign w_idx  = IDX_W'((r_addr - BASE_ADDRESS) >> 2);
  assign w_lane = {r_addr[1:0], 3'b000};
  assign w_word = r_mem[w_idx];
  assign w_load = r_byte ? {{(ADDRESS_SIZE-8){1'b0}}, w_word[w_lane +: 8]} : w_word;

  // Response registers, loaded on the BUSY->RESP edge and held through RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_error <= 1'b0;
    end else if (w_fire) begin
      r_error <= w_err;
      r_rdata <= (w_err || r_write) ? '0 : w_load;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_error = r_error;

  // Storage is not reset. A reset while in BUSY leaves the state at IDLE, so the
  // in-flight write never fires.
  always_ff @(posedge clk) begin
    if (w_fire && r_write && !w_err) begin
      if (r_byte) r_mem[w_idx][w_lane +: 8] <= r_wdata[7:0];
      else        r_mem[w_idx]              <= r_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h1000;
  localparam logic [31:0] MSIZE = 32'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  // LATENCY=3 instance
  logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;

  // LATENCY=1 instance
  logic        req1_valid = 1'b0, req1_write = 1'b0, req1_byte = 1'b0, resp1_ready = 1'b1;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic        req1_ready, resp1_valid, resp1_error;
  logic [31:0] resp1_rdata;

  mem_responder #(.ADDRESS_SIZE(32), .BASE_ADDRESS(BASE), .MEM_SIZE(MSIZE), .LATENCY(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  mem_responder #(.ADDRESS_SIZE(32), .BASE_ADDRESS(BASE), .MEM_SIZE(MSIZE), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req1_valid), .req_ready(req1_ready), .req_write(req1_write), .req_byte(req1_byte),
    .req_addr(req1_addr), .req_wdata(req1_wdata),
    .resp_valid(resp1_valid), .resp_ready(resp1_ready), .resp_rdata(resp1_rdata), .resp_error(resp1_error)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] sb_q[$];
  logic [32:0] sb1_q[$];
  logic [31:0] mdl [int unsigned];
  logic [32:0] mon1_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference memory: word-indexed, unwritten words read as zero.
  task automatic model(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
    logic [63:0] endp;
    logic [31:0] word;
    int unsigned idx;
    int          lane;
    endp = {32'h0, a} + (b ? 64'd1 : 64'd4);
    e = (a < BASE) || (endp > ({32'h0, BASE} + {32'h0, MSIZE})) || (!b && (a[1:0] != 2'b00));
    r = '0;
    if (!e) begin
      idx  = (a - BASE) >> 2;
      lane = int'(a[1:0]);
      word = mdl.exists(idx) ? mdl[idx] : 32'h0;
      if (w) begin
        if (b) word[lane*8 +: 8] = d[7:0];
        else   word = d;
        mdl[idx] = word;
      end else begin
        r = b ? {24'h0, word[lane*8 +: 8]} : word;
      end
    end
  endtask

  // One full transaction on the LATENCY=3 instance; stall>0 holds resp_ready low.
  task automatic do_req(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                        input int stall);
    logic [31:0] er;
    logic        ee;
    logic [32:0] ev;
    logic [31:0] held;
    int          n;
    model(w, b, a, d, er, ee);
    sb_q.push_back({ee, er});
    req_write = w; req_byte = b; req_addr = a; req_wdata = d; req_valid = 1'b1;
    resp_ready = (stall == 0);
    n = 0;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a; req_write = ~w; req_wdata = ~d;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("latency", n, 32'd3);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      ev = sb_q.pop_front();
      check("rdata", resp_rdata, ev[31:0]);
      check("error", {31'b0, resp_error}, {31'b0, ev[32]});
    end
    if (stall > 0) begin
      held = resp_rdata;
      for (int i = 0; i < stall; i++) begin
        if (i == 1) begin
          req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
          req_addr = BASE + 32'h8; req_wdata = 32'hFFFFFFFF;
        end
        if (i == 2) req_valid = 1'b0;
        @(posedge clk); #1;
        check("stall_valid", {31'b0, resp_valid}, 32'd1);
        check("stall_rdata", resp_rdata, held);
        check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("post_hs_valid", {31'b0, resp_valid}, 32'd0);
    check("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  // Scoreboard side of the LATENCY=1 instance
  always @(posedge clk) begin
    #1;
    if (reset && resp1_valid) begin
      check("l1_sb_nonempty", {31'b0, sb1_q.size() != 0}, 32'd1);
      if (sb1_q.size() != 0) begin
        mon1_e = sb1_q.pop_front();
        check("l1_rdata", resp1_rdata, mon1_e[31:0]);
        check("l1_error", {31'b0, resp1_error}, {31'b0, mon1_e[32]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          seen;
    int          n;
    int          acc_cyc[$];
    logic [31:0] d1 [4];
    d1[0] = 32'h01020304; d1[1] = 32'hA5A55A5A; d1[2] = 32'h0F0F0F0F; d1[3] = 32'h87654321;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", {31'b0, resp_error}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Word store / load
    do_req(1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 0);
    do_req(1'b0, 1'b0, 32'h1000, 32'h0, 0);
    // Byte lanes
    do_req(1'b1, 1'b1, 32'h1002, 32'h00000055, 0);
    do_req(1'b0, 1'b0, 32'h1000, 32'h0, 0);
    do_req(1'b0, 1'b1, 32'h1003, 32'h0, 0);
    // Range and alignment
    do_req(1'b1, 1'b0, 32'h1FFC, 32'hA1B2C3D4, 0);
    do_req(1'b0, 1'b0, 32'h0FFC, 32'h0, 0);
    do_req(1'b0, 1'b0, 32'h1FFE, 32'h0, 0);
    do_req(1'b1, 1'b0, 32'h2000, 32'hFFFFFFFF, 0);
    do_req(1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 0);
    do_req(1'b1, 1'b0, 32'h1002, 32'h99999999, 0);
    do_req(1'b0, 1'b1, 32'h0FFF, 32'h0, 0);
    do_req(1'b0, 1'b1, 32'h1FFF, 32'h0, 0);
    do_req(1'b0, 1'b0, 32'h1FFC, 32'h0, 0);
    do_req(1'b0, 1'b0, 32'h1000, 32'h0, 0);
    // Response backpressure with a stray request in RESP
    do_req(1'b1, 1'b0, 32'h1008, 32'h11223344, 0);
    do_req(1'b0, 1'b0, 32'h1000, 32'h0, 5);
    do_req(1'b0, 1'b0, 32'h1008, 32'h0, 0);

    // Reset during BUSY of a store
    do_req(1'b1, 1'b0, 32'h1004, 32'hCAFEF00D, 0);
    do_req(1'b0, 1'b0, 32'h1004, 32'h0, 0);
    req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h1004; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_req_ready", {31'b0, req_ready}, 32'd0);
    check("busy_rdata_held", resp_rdata, 32'hCAFEF00D);
    reset = 1'b0;
    #1;
    check("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("arst_rdata", resp_rdata, 32'd0);
    check("arst_error", {31'b0, resp_error}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_req_ready", {31'b0, req_ready}, 32'd1);
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (resp_valid) seen++; end
    check("no_resp_after_rst", seen, 32'd0);
    do_req(1'b0, 1'b0, 32'h1004, 32'h0, 0);

    // LATENCY=1 back-to-back with resp_ready tied high
    for (int k = 0; k < 8; k++) begin
      req1_write = (k < 4); req1_byte = 1'b0;
      req1_addr = BASE + 32'(4 * (k % 4)); req1_wdata = d1[k % 4]; req1_valid = 1'b1;
      n = 0;
      while (!req1_ready && n < 20) begin @(posedge clk); #1; n++; end
      check("l1_accept", {31'b0, req1_ready}, 32'd1);
      sb1_q.push_back((k < 4) ? 33'h0 : {1'b0, d1[k % 4]});
      acc_cyc.push_back(cyc_cnt);
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    for (int k = 1; k < 8; k++) check("l1_spacing", acc_cyc[k] - acc_cyc[k-1], 32'd3);
    repeat (6) @(posedge clk);
    #2;
    check("l1_drained", sb1_q.size(), 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 32, address and data width.
REQ-002 SHALL have parameter BASE_ADDRESS, default 32'h1000, first byte address served.
REQ-003 SHALL have parameter MEM_SIZE, default 32'h1000, bytes of storage; a multiple of 4.
REQ-004 SHALL have parameter LATENCY, default 3, cycles from request acceptance to response; legal range 1..15.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, requester presents a request.
REQ-008 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-009 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port req_byte, input, 1, 1 = byte access, 0 = word access.
REQ-011 SHALL have port req_addr, input, ADDRESS_SIZE, byte address.
REQ-012 SHALL have port req_wdata, input, ADDRESS_SIZE, store data; byte stores use bits [7:0].
REQ-013 SHALL have port resp_valid, output, 1, response available.
REQ-014 SHALL have port resp_ready, input, 1, requester accepts the response.
REQ-015 SHALL have port resp_rdata, output, ADDRESS_SIZE, load data; 0 for stores and errors.
REQ-016 SHALL have port resp_error, output, 1, request was out of range or misaligned.

Function
REQ-017 SHALL implement the FSM states IDLE, BUSY and RESP, with at most one request outstanding.
REQ-018 SHALL drive req_ready=1 only in IDLE and resp_valid=1 only in RESP.
REQ-019 SHALL accept a request on a rising edge with req_valid&&req_ready, capture write/byte/addr/wdata, load the counter with LATENCY-1, and enter BUSY.
REQ-020 SHALL, in BUSY, decrement the counter each cycle and enter RESP on the edge where the counter is 0, so resp_valid first rises LATENCY cycles after the acceptance edge.
REQ-021 SHALL perform the memory access on the BUSY->RESP edge and register resp_rdata/resp_error on that same edge.
REQ-022 SHALL hold resp_valid, resp_rdata and resp_error stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-023 SHALL therefore accept the next request no earlier than the cycle after the response handshake, because req_ready=0 in RESP.
REQ-024 SHALL use a little-endian layout: the byte at offset addr-BASE_ADDRESS maps to word (offset>>2), lane offset[1:0].
REQ-025 SHALL zero-extend byte loads into bits [7:0], and SHALL have byte stores modify only the addressed lane.
REQ-026 SHALL flag an error when addr<BASE_ADDRESS, when addr+size>BASE_ADDRESS+MEM_SIZE (size is 1 or 4), or when a word access has addr[1:0]!=0.
REQ-027 SHALL, on error, leave memory unmodified, set resp_rdata=0 and resp_error=1, and keep the normal latency and handshake.
REQ-028 SHALL treat the address comparison as unsigned with no wrap-around: addr=32'hFFFFFFFC word is an error.
REQ-029 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-030 SHALL, while reset=0, immediately force state=IDLE, counter=0, req_ready=1 after release, resp_valid=0, resp_rdata=0 and resp_error=0.
REQ-031 SHALL discard an in-flight request on reset during BUSY or RESP, with no memory write and no response afterward.
REQ-032 SHALL NOT clear memory contents on reset.

Verification
REQ-033 SHALL cover: LATENCY=3, store word 32'hDEADBEEF @32'h1000, then load word @32'h1000 -> resp_valid 3 cycles after each acceptance; load returns 32'hDEADBEEF with resp_error=0.
REQ-034 SHALL cover: after REQ-033, byte store 8'h55 @32'h1002, then word load @32'h1000 -> 32'hDE55BEEF; byte load @32'h1003 -> 32'h000000DE.
REQ-035 SHALL cover: word load @32'h0FFC, word load @32'h1FFE, word store @32'h2000 -> each resp_error=1, resp_rdata=0, memory unchanged; byte load @32'h1FFF -> resp_error=0.
REQ-036 SHALL cover: resp_ready held low 5 cycles in RESP -> resp_valid and resp_rdata stable; req_valid pulsed meanwhile is ignored; req_ready rises the cycle after the handshake.
REQ-037 SHALL cover: reset=0 asserted one cycle into BUSY of a store 32'h12345678 @32'h1004 -> outputs clear asynchronously, no response appears, and a later load @32'h1004 returns the prior contents.
REQ-038 SHALL cover: LATENCY=1 with back-to-back requests and resp_ready tied high -> one request accepted every 3 cycles (IDLE, BUSY, RESP).
